// File: rtl/seg_message_sequencer.sv
// Seven-segment message sequencer: debounced step/mode buttons drive a
// MANUAL/AUTO/BLANK mode FSM that walks a fixed 14-frame segment ROM.
module seg_message_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_CYCLES     = 12_000_000,
  parameter int unsigned MSG_LEN         = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       btn_mode,
  input  logic       pause,
  input  logic       dir,
  output logic [7:0] seg_out,
  output logic [3:0] index,
  output logic [1:0] mode,
  output logic       step_tick
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    BLANK  = 2'b10
  } mode_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] TICK_LAST = 24'(TICK_CYCLES - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(MSG_LEN - 1);

  // Bit 0 is the step button, bit 1 the mode button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1, sync2, deb, deb_d, pulse;
  logic [15:0] deb_cnt [2];
  logic        step_p, mode_p;

  assign btn_raw = {btn_mode, btn_step};
  assign step_p  = pulse[0];
  assign mode_p  = pulse[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_d      <= '0;
      pulse      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 16'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  mode_t       state, state_next;
  logic [23:0] presc, presc_next;
  logic [3:0]  idx, idx_next;
  logic        advance, tick;
  logic [7:0]  rom_val;

  // The advance decision uses the current mode, so a simultaneous mode press
  // still applies the step under the old mode's rules.
  always_comb begin
    state_next = state;
    presc_next = '0;
    tick       = 1'b0;
    advance    = 1'b0;
    case (state)
      MANUAL: begin
        advance = step_p;
        if (mode_p) state_next = AUTO;
      end
      AUTO: begin
        tick    = !pause && (presc == TICK_LAST);
        advance = step_p | tick;
        if (step_p || tick) presc_next = '0;
        else if (pause)     presc_next = presc;
        else                presc_next = presc + 24'd1;
        if (mode_p) state_next = BLANK;
      end
      BLANK: begin
        if (mode_p) state_next = MANUAL;
      end
      default: state_next = MANUAL;
    endcase
    if (mode_p) presc_next = '0;

    idx_next = idx;
    if (advance) begin
      if (dir) idx_next = (idx == 4'd0) ? IDX_LAST : idx - 4'd1;
      else     idx_next = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
    end
  end

  always_comb begin
    case (idx)
      4'd0:    rom_val = 8'h80;
      4'd1:    rom_val = 8'h5B;
      4'd2:    rom_val = 8'h4F;
      4'd3:    rom_val = 8'h15;
      4'd4:    rom_val = 8'h7E;
      4'd5:    rom_val = 8'h0E;
      4'd6:    rom_val = 8'h5F;
      4'd7:    rom_val = 8'h3E;
      4'd8:    rom_val = 8'h0E;
      4'd9:    rom_val = 8'h5F;
      4'd10:   rom_val = 8'h7E;
      4'd11:   rom_val = 8'h15;
      4'd12:   rom_val = 8'h3E;
      4'd13:   rom_val = 8'h0E;
      default: rom_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MANUAL;
      presc     <= '0;
      idx       <= '0;
      step_tick <= 1'b0;
      seg_out   <= '0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      idx       <= idx_next;
      step_tick <= advance;
      seg_out   <= (state == BLANK) ? 8'h00 : rom_val;
    end
  end

  assign index = idx;
  assign mode  = state;

endmodule

// File: tb/tb_seg_message_sequencer.sv
// Directed bench for seg_message_sequencer with DEBOUNCE_CYCLES=4, TICK_CYCLES=5.
module tb_seg_message_sequencer;

  localparam int DEB  = 4;
  localparam int TICK = 5;
  localparam int M_MANUAL = 0;
  localparam int M_AUTO   = 1;
  localparam int M_BLANK  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b0;
  logic       btn_mode = 1'b0;
  logic       pause = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] seg_out;
  logic [3:0] index;
  logic [1:0] mode;
  logic       step_tick;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;

  seg_message_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES(TICK),
    .MSG_LEN(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .pause(pause),
    .dir(dir),
    .seg_out(seg_out),
    .index(index),
    .mode(mode),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       d;
    logic [3:0] idx;
    logic [7:0] seg;
  } vec_t;

  vec_t vecs [17];

  task automatic cyc();
    @(posedge clk);
    #1;
    if (step_tick) tick_cnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_step(input logic d);
    dir = d;
    btn_step = 1'b1;
    repeat (8) cyc();
    btn_step = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic wait_change(output int n);
    int old;
    old = int'(index);
    n = 0;
    while (int'(index) == old && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_mode_change(output int n);
    int old;
    old = int'(mode);
    n = 0;
    while (int'(mode) == old && n < 20) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, base;

    vecs[0]  = '{1'b0, 4'd1,  8'h5B};
    vecs[1]  = '{1'b0, 4'd2,  8'h4F};
    vecs[2]  = '{1'b0, 4'd3,  8'h15};
    vecs[3]  = '{1'b0, 4'd4,  8'h7E};
    vecs[4]  = '{1'b0, 4'd5,  8'h0E};
    vecs[5]  = '{1'b0, 4'd6,  8'h5F};
    vecs[6]  = '{1'b0, 4'd7,  8'h3E};
    vecs[7]  = '{1'b0, 4'd8,  8'h0E};
    vecs[8]  = '{1'b0, 4'd9,  8'h5F};
    vecs[9]  = '{1'b0, 4'd10, 8'h7E};
    vecs[10] = '{1'b0, 4'd11, 8'h15};
    vecs[11] = '{1'b0, 4'd12, 8'h3E};
    vecs[12] = '{1'b0, 4'd13, 8'h0E};
    vecs[13] = '{1'b0, 4'd0,  8'h80};
    vecs[14] = '{1'b1, 4'd13, 8'h0E};
    vecs[15] = '{1'b1, 4'd12, 8'h3E};
    vecs[16] = '{1'b0, 4'd13, 8'h0E};

    // Reset state
    repeat (2) cyc();
    chk("rst_index", int'(index), 0);
    chk("rst_mode", int'(mode), M_MANUAL);
    chk("rst_seg", int'(seg_out), 8'h00);
    chk("rst_step_tick", int'(step_tick), 0);
    rst = 1'b0;
    cyc();
    chk("seg_after_rst", int'(seg_out), 8'h80);

    // ROM walk, forward wrap and backward wrap
    for (int i = 0; i < 17; i++) begin
      t0 = tick_cnt;
      do_step(vecs[i].d);
      chk($sformatf("walk%0d_index", i), int'(index), int'(vecs[i].idx));
      chk($sformatf("walk%0d_seg", i), int'(seg_out), int'(vecs[i].seg));
      chk($sformatf("walk%0d_pulses", i), tick_cnt - t0, 1);
    end

    // 3-cycle glitch is rejected
    dir = 1'b0;
    t0 = tick_cnt;
    btn_step = 1'b1;
    repeat (3) cyc();
    btn_step = 1'b0;
    repeat (12) cyc();
    chk("glitch_index", int'(index), 13);
    chk("glitch_pulses", tick_cnt - t0, 0);

    // Exact press-to-index latency, forward wrap 13 -> 0
    btn_step = 1'b1;
    wait_change(n);
    chk("latency_edges", n - 1, DEB + 3);
    chk("latency_index", int'(index), 0);
    chk("latency_step_tick", int'(step_tick), 1);
    cyc();
    chk("latency_seg", int'(seg_out), 8'h80);
    chk("latency_step_tick_gone", int'(step_tick), 0);
    btn_step = 1'b0;
    repeat (8) cyc();

    // Bouncing release followed by re-press gives one step
    t0 = tick_cnt;
    btn_step = 1'b1;
    repeat (10) cyc();
    btn_step = 1'b0;
    cyc();
    btn_step = 1'b1;
    cyc();
    btn_step = 1'b0;
    repeat (2) cyc();
    btn_step = 1'b1;
    repeat (10) cyc();
    btn_step = 1'b0;
    repeat (10) cyc();
    chk("bounce_index", int'(index), 1);
    chk("bounce_pulses", tick_cnt - t0, 1);

    // MANUAL -> AUTO, then periodic ticks
    btn_mode = 1'b1;
    wait_mode_change(n);
    btn_mode = 1'b0;
    chk("mode_latency", n - 1, DEB + 3);
    chk("auto_mode", int'(mode), M_AUTO);
    chk("auto_index_held", int'(index), 1);
    wait_change(n);
    chk("auto_gap1", n, TICK);
    chk("auto_idx1", int'(index), 2);
    wait_change(n);
    chk("auto_gap2", n, TICK);
    chk("auto_idx2", int'(index), 3);

    // Pause for 7 cycles stretches the gap to 12
    pause = 1'b1;
    repeat (7) cyc();
    chk("pause_index_held", int'(index), 3);
    pause = 1'b0;
    wait_change(n);
    chk("pause_gap", n + 7, 12);
    chk("pause_idx", int'(index), 4);

    // Step pulse landing on the same edge as a tick: one advance
    base = int'(index);
    t0 = tick_cnt;
    repeat (2) cyc();
    btn_step = 1'b1;
    for (int off = 3; off <= 15; off++) begin
      cyc();
      if (off == 10) begin
        chk("coincide_idx", int'(index), base + 2);
        btn_step = 1'b0;
      end
      if (off == 14) chk("coincide_hold", int'(index), base + 2);
      if (off == 15) chk("coincide_next", int'(index), base + 3);
    end
    chk("coincide_pulses", tick_cnt - t0, 3);
    wait_change(n);
    chk("auto_gap3", n, TICK);
    chk("auto_idx3", int'(index), 8);

    // Step mid-count restarts the interval
    btn_step = 1'b1;
    for (int off = 1; off <= 13; off++) begin
      cyc();
      if (off == 5) chk("midstep_tick_idx", int'(index), 9);
      if (off == 8) begin
        chk("midstep_step_idx", int'(index), 10);
        btn_step = 1'b0;
      end
      if (off == 12) chk("midstep_hold", int'(index), 10);
      if (off == 13) chk("midstep_restart", int'(index), 11);
    end

    // AUTO -> BLANK (one tick lands during the press)
    btn_mode = 1'b1;
    wait_mode_change(n);
    btn_mode = 1'b0;
    chk("blank_mode", int'(mode), M_BLANK);
    chk("blank_index", int'(index), 12);
    cyc();
    chk("blank_seg", int'(seg_out), 8'h00);
    t0 = tick_cnt;
    do_step(1'b0);
    repeat (20) cyc();
    chk("blank_step_ignored", int'(index), 12);
    chk("blank_seg_held", int'(seg_out), 8'h00);
    chk("blank_pulses", tick_cnt - t0, 0);

    // BLANK -> MANUAL restores the frame
    btn_mode = 1'b1;
    repeat (8) cyc();
    btn_mode = 1'b0;
    repeat (8) cyc();
    chk("manual_mode", int'(mode), M_MANUAL);
    chk("manual_seg", int'(seg_out), 8'h3E);

    // Mode and step together from MANUAL
    btn_mode = 1'b1;
    btn_step = 1'b1;
    wait_mode_change(n);
    chk("simul_mode", int'(mode), M_AUTO);
    chk("simul_index", int'(index), 13);
    chk("simul_step_tick", int'(step_tick), 1);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    repeat (8) cyc();
    wait_change(n);
    chk("simul_auto_idx", int'(index), 1);

    // Reset mid-debounce with prescaler at 3
    btn_step = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    btn_step = 1'b0;
    cyc();
    chk("midrst_index", int'(index), 0);
    chk("midrst_mode", int'(mode), M_MANUAL);
    chk("midrst_seg", int'(seg_out), 8'h00);
    chk("midrst_step_tick", int'(step_tick), 0);
    rst = 1'b0;
    t0 = tick_cnt;
    cyc();
    chk("midrst_seg_release", int'(seg_out), 8'h80);
    repeat (15) cyc();
    chk("midrst_no_late_step", int'(index), 0);
    chk("midrst_pulses", tick_cnt - t0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
